// File: rtl/vector_pkg.sv
// Shared definitions for the vector frame builder: point word layout,
// command codes and the builder FSM state type.
package vector_pkg;

    localparam logic [1:0] CMD_DRAW = 2'b00;
    localparam logic [1:0] CMD_MOVE = 2'b01;
    localparam logic [1:0] CMD_END  = 2'b11;

    localparam int X_MSB   = 17;
    localparam int X_LSB   = 10;
    localparam int Y_MSB   = 9;
    localparam int Y_LSB   = 2;
    localparam int CMD_MSB = 1;
    localparam int CMD_LSB = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [1:0] cmd;
    } point_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SNAPSHOT = 3'd1,
        ST_SELECT   = 3'd2,
        ST_COPY     = 3'd3,
        ST_TERM     = 3'd4,
        ST_READY    = 3'd5
    } fsm_state_t;

    // Both END (11) and the unused code 10 terminate a sprite.
    function automatic logic is_end(input logic [1:0] cmd);
        return cmd[1];
    endfunction

endpackage

// File: rtl/point_translate.sv
// Adds a signed sprite offset to an unsigned screen origin and either
// saturates to the screen range or wraps modulo the screen size.
module point_translate #(
    parameter int OUT_WIDTH = 8,
    parameter int OFF_WIDTH = 8,
    parameter int CLIP_MODE = 1
) (
    input  logic [OUT_WIDTH-1:0] origin,
    input  logic [OFF_WIDTH-1:0] offset,
    output logic [OUT_WIDTH-1:0] coord
);

    localparam int SW = OUT_WIDTH + 2;

    // Two guard bits: the top one flags a negative sum, the next one a sum past the screen.
    logic signed [SW-1:0] sum;
    assign sum = $signed({2'b00, origin}) + SW'($signed(offset));

    generate
        if (CLIP_MODE != 0) begin : g_clip
            always_comb begin
                coord = sum[OUT_WIDTH-1:0];
                if (sum[SW-1])
                    coord = '0;
                else if (sum[SW-2])
                    coord = '1;
            end
        end else begin : g_wrap
            assign coord = sum[OUT_WIDTH-1:0];
        end
    endgenerate

endmodule

// File: rtl/vector_frame_builder.sv
// Builds one vector point list per display frame from NUM_OBJ sprite channels
// into the display RAM, then hands it to the display through go/halt.
module vector_frame_builder
    import vector_pkg::*;
#(
    parameter int ADR_WIDTH      = 16,
    parameter int DATAWIDTH      = 18,
    parameter int OUT_WIDTH      = 8,
    parameter int NUM_OBJ        = 4,
    parameter int RAM_DEPTH      = 1000,
    parameter int MAX_SPRITE_LEN = 256,
    parameter int CLIP_MODE      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_OBJ-1:0]             obj_valid,
    input  logic [NUM_OBJ*OUT_WIDTH-1:0]   obj_x,
    input  logic [NUM_OBJ*OUT_WIDTH-1:0]   obj_y,
    input  logic [NUM_OBJ*ADR_WIDTH-1:0]   obj_adr,
    output logic [ADR_WIDTH-1:0]           rom_adr,
    input  logic [DATAWIDTH-1:0]           rom_data,
    output logic [ADR_WIDTH-1:0]           ram_wadr,
    output logic [DATAWIDTH-1:0]           ram_wdata,
    output logic                           ram_we,
    output logic                           go,
    input  logic                           halt,
    output logic [ADR_WIDTH-1:0]           frame_len,
    output logic                           overflow,
    output fsm_state_t                     dbg_state
);

    localparam int IDXW    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int CNTW    = $clog2(MAX_SPRITE_LEN + 1);
    localparam int OFF_W   = X_MSB - X_LSB + 1;

    fsm_state_t                   state;
    logic [NUM_OBJ-1:0]           snap_valid;
    logic [NUM_OBJ*OUT_WIDTH-1:0] snap_x;
    logic [NUM_OBJ*OUT_WIDTH-1:0] snap_y;
    logic [NUM_OBJ*ADR_WIDTH-1:0] snap_adr;
    logic [IDXW-1:0]              idx;
    logic [CNTW-1:0]              spr_cnt;
    logic [ADR_WIDTH-1:0]         wptr;

    logic [OUT_WIDTH-1:0] cur_x, cur_y, tx, ty;
    logic [ADR_WIDTH-1:0] cur_adr;
    logic                 last_ch, word_end, len_hit, ram_full, point_write;

    assign cur_x   = snap_x[idx*OUT_WIDTH +: OUT_WIDTH];
    assign cur_y   = snap_y[idx*OUT_WIDTH +: OUT_WIDTH];
    assign cur_adr = snap_adr[idx*ADR_WIDTH +: ADR_WIDTH];
    assign last_ch = (idx == IDXW'(NUM_OBJ - 1));

    // The top RAM word is kept free so the end marker always fits.
    assign word_end    = is_end(rom_data[CMD_MSB:CMD_LSB]);
    assign len_hit     = (spr_cnt == CNTW'(MAX_SPRITE_LEN));
    assign ram_full    = (wptr == ADR_WIDTH'(RAM_DEPTH - 1));
    assign point_write = (state == ST_COPY) && !word_end && !len_hit && !ram_full;

    point_translate #(.OUT_WIDTH(OUT_WIDTH), .OFF_WIDTH(OFF_W), .CLIP_MODE(CLIP_MODE)) u_tx (
        .origin (cur_x),
        .offset (rom_data[X_MSB:X_LSB]),
        .coord  (tx)
    );

    point_translate #(.OUT_WIDTH(OUT_WIDTH), .OFF_WIDTH(OFF_W), .CLIP_MODE(CLIP_MODE)) u_ty (
        .origin (cur_y),
        .offset (rom_data[Y_MSB:Y_LSB]),
        .coord  (ty)
    );

    assign ram_we    = point_write || (state == ST_TERM);
    assign ram_wadr  = wptr;
    assign dbg_state = state;

    always_comb begin
        ram_wdata = '0;
        if (point_write)
            ram_wdata = DATAWIDTH'({tx, ty, rom_data[CMD_MSB:CMD_LSB]});
        else if (state == ST_TERM)
            ram_wdata = DATAWIDTH'({{(2*OUT_WIDTH){1'b0}}, CMD_END});
    end

    // go/halt: go rises with the finished frame and stays high, frame_len and
    // overflow frozen, until halt is seen high in READY; go drops on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            snap_valid <= '0;
            snap_x     <= '0;
            snap_y     <= '0;
            snap_adr   <= '0;
            idx        <= '0;
            spr_cnt    <= '0;
            wptr       <= '0;
            rom_adr    <= '0;
            go         <= 1'b0;
            frame_len  <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_SNAPSHOT;
                ST_SNAPSHOT: begin
                    snap_valid <= obj_valid;
                    snap_x     <= obj_x;
                    snap_y     <= obj_y;
                    snap_adr   <= obj_adr;
                    wptr       <= '0;
                    idx        <= '0;
                    overflow   <= 1'b0;
                    state      <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (snap_valid[idx]) begin
                        rom_adr <= cur_adr;
                        spr_cnt <= '0;
                        state   <= ST_COPY;
                    end else if (last_ch) begin
                        state <= ST_TERM;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_COPY: begin
                    if (word_end || len_hit) begin
                        if (last_ch) begin
                            state <= ST_TERM;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_SELECT;
                        end
                    end else if (ram_full) begin
                        overflow <= 1'b1;
                        state    <= ST_TERM;
                    end else begin
                        wptr    <= wptr + 1'b1;
                        rom_adr <= rom_adr + 1'b1;
                        spr_cnt <= spr_cnt + 1'b1;
                    end
                end
                ST_TERM: begin
                    frame_len <= wptr + 1'b1;
                    go        <= 1'b1;
                    state     <= ST_READY;
                end
                ST_READY: begin
                    if (halt) begin
                        go    <= 1'b0;
                        state <= ST_SNAPSHOT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_frame_builder.sv
// Bench for vector_frame_builder: two instances (saturating, MAX_SPRITE_LEN=16;
// wrapping, RAM_DEPTH=8) share one sprite ROM and are checked against a frame model.
module tb_vector_frame_builder;
    import vector_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus state ----------------
    logic [3:0]  v_a, v_b;
    logic [7:0]  x_a[4], y_a[4], x_b[4], y_b[4];
    logic [15:0] adr_a[4], adr_b[4];
    logic        halt_a, halt_b;

    logic [31:0] obj_x_a, obj_y_a, obj_x_b, obj_y_b;
    logic [63:0] obj_adr_a, obj_adr_b;
    always_comb begin
        obj_x_a = '0; obj_y_a = '0; obj_adr_a = '0;
        obj_x_b = '0; obj_y_b = '0; obj_adr_b = '0;
        for (int i = 0; i < 4; i++) begin
            obj_x_a[i*8 +: 8]    = x_a[i];
            obj_y_a[i*8 +: 8]    = y_a[i];
            obj_adr_a[i*16 +: 16] = adr_a[i];
            obj_x_b[i*8 +: 8]    = x_b[i];
            obj_y_b[i*8 +: 8]    = y_b[i];
            obj_adr_b[i*16 +: 16] = adr_b[i];
        end
    end

    logic [17:0] rom [0:65535];

    logic [15:0] rom_adr_a, ram_wadr_a, frame_len_a, rom_adr_b, ram_wadr_b, frame_len_b;
    logic [17:0] rom_data_a, ram_wdata_a, rom_data_b, ram_wdata_b;
    logic        ram_we_a, go_a, overflow_a, ram_we_b, go_b, overflow_b;
    fsm_state_t  st_a, st_b;

    assign rom_data_a = rom[rom_adr_a];
    assign rom_data_b = rom[rom_adr_b];

    vector_frame_builder #(.CLIP_MODE(1), .MAX_SPRITE_LEN(16)) dut_a (
        .clk(clk), .rst(rst), .obj_valid(v_a), .obj_x(obj_x_a), .obj_y(obj_y_a),
        .obj_adr(obj_adr_a), .rom_adr(rom_adr_a), .rom_data(rom_data_a),
        .ram_wadr(ram_wadr_a), .ram_wdata(ram_wdata_a), .ram_we(ram_we_a),
        .go(go_a), .halt(halt_a), .frame_len(frame_len_a), .overflow(overflow_a),
        .dbg_state(st_a)
    );

    vector_frame_builder #(.CLIP_MODE(0), .RAM_DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .obj_valid(v_b), .obj_x(obj_x_b), .obj_y(obj_y_b),
        .obj_adr(obj_adr_b), .rom_adr(rom_adr_b), .rom_data(rom_data_b),
        .ram_wadr(ram_wadr_b), .ram_wdata(ram_wdata_b), .ram_we(ram_we_b),
        .go(go_b), .halt(halt_b), .frame_len(frame_len_b), .overflow(overflow_b),
        .dbg_state(st_b)
    );

    // ---------------- RAM write log ----------------
    int          wadr_a_log[$], wadr_b_log[$];
    logic [17:0] wdat_a_log[$], wdat_b_log[$];
    always @(posedge clk) begin
        if (ram_we_a === 1'b1) begin
            wadr_a_log.push_back(int'(ram_wadr_a));
            wdat_a_log.push_back(ram_wdata_a);
        end
        if (ram_we_b === 1'b1) begin
            wadr_b_log.push_back(int'(ram_wadr_b));
            wdat_b_log.push_back(ram_wdata_b);
        end
    end

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [17:0] exp_q_a[$], exp_q_b[$];
    int          exp_cyc_a, exp_cyc_b;
    bit          exp_ovf_a, exp_ovf_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] mkw(input int x, input int y, input logic [1:0] c);
        return {x[7:0], y[7:0], c};
    endfunction

    function automatic int fold(input int o, input int off, input bit clip);
        int s;
        s = o + off;
        if (clip) begin
            if (s < 0) return 0;
            if (s > 255) return 255;
            return s;
        end
        return s & 255;
    endfunction

    // Frame model: walk each channel's sprite in ROM and list the words the frame should hold.
    task automatic model(input bit sel);
        logic [17:0] q[$];
        logic [17:0] w;
        logic [3:0]  v;
        int ox[4], oy[4], ad[4];
        int depth, maxl, cyc, a, n;
        bit clip, ovf;
        if (sel) begin
            clip = 0; depth = 8; maxl = 256; v = v_b;
            for (int i = 0; i < 4; i++) begin ox[i] = int'(x_b[i]); oy[i] = int'(y_b[i]); ad[i] = int'(adr_b[i]); end
        end else begin
            clip = 1; depth = 1000; maxl = 16; v = v_a;
            for (int i = 0; i < 4; i++) begin ox[i] = int'(x_a[i]); oy[i] = int'(y_a[i]); ad[i] = int'(adr_a[i]); end
        end
        cyc = 1;
        ovf = 0;
        for (int ch = 0; ch < 4; ch++) begin
            if (ovf) break;
            cyc++;
            if (!v[ch]) continue;
            a = ad[ch];
            n = 0;
            while (1) begin
                cyc++;
                w = rom[a[15:0]];
                if (w[1] || n == maxl) break;
                if (q.size() == depth - 1) begin ovf = 1; break; end
                q.push_back(mkw(fold(ox[ch], int'($signed(w[17:10])), clip),
                                fold(oy[ch], int'($signed(w[9:2])), clip), w[1:0]));
                a++;
                n++;
            end
        end
        q.push_back(mkw(0, 0, 2'b11));
        cyc++;
        if (sel) begin exp_q_b = q; exp_cyc_b = cyc; exp_ovf_b = ovf; end
        else     begin exp_q_a = q; exp_cyc_a = cyc; exp_ovf_a = ovf; end
    endtask

    task automatic check_frame(input bit sel, input int base, input int cyc);
        logic [17:0] eq[$];
        int  ecyc, nw;
        bit  eovf;
        string p;
        p = sel ? "b" : "a";
        if (sel) begin eq = exp_q_b; ecyc = exp_cyc_b; eovf = exp_ovf_b; nw = wdat_b_log.size() - base; end
        else     begin eq = exp_q_a; ecyc = exp_cyc_a; eovf = exp_ovf_a; nw = wdat_a_log.size() - base; end
        check({p, "_nwrites"}, 64'(nw), 64'(eq.size()));
        for (int i = 0; i < nw && i < eq.size(); i++) begin
            check($sformatf("%s_wadr%0d", p, i), 64'(sel ? wadr_b_log[base+i] : wadr_a_log[base+i]), 64'(i));
            check($sformatf("%s_wdata%0d", p, i), 64'(sel ? wdat_b_log[base+i] : wdat_a_log[base+i]), 64'(eq[i]));
        end
        check({p, "_frame_len"}, 64'(sel ? frame_len_b : frame_len_a), 64'(eq.size()));
        check({p, "_overflow"}, 64'(sel ? overflow_b : overflow_a), 64'(eovf));
        check({p, "_latency"}, 64'(cyc), 64'(ecyc + 1));
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_halt(input bit sel, output int cyc);
        if (sel) halt_b = 1'b1; else halt_a = 1'b1;
        @(negedge clk);
        halt_a = 1'b0;
        halt_b = 1'b0;
        check(sel ? "b_go_drop" : "a_go_drop", 64'(sel ? go_b : go_a), 64'(0));
        cyc = 1;
        while (cyc < 3000 && (sel ? go_b : go_a) !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_frame(input bit sel, output int base);
        int cyc;
        model(sel);
        base = sel ? wdat_b_log.size() : wdat_a_log.size();
        pulse_halt(sel, cyc);
        check_frame(sel, base, cyc);
    endtask

    task automatic wait_both(input bit mutate, output int ca, output int cb);
        ca = -1;
        cb = -1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (mutate && c == 2) begin
                v_a = 4'b1111;
                for (int i = 0; i < 4; i++) begin
                    x_a[i] = 8'($urandom_range(0, 255));
                    adr_a[i] = 16'h0500;
                end
            end
            if (ca < 0 && go_a === 1'b1) ca = c;
            if (cb < 0 && go_b === 1'b1) cb = c;
            if (ca >= 0 && cb >= 0) break;
        end
    endtask

    task automatic fill_region(input int base, input int npts, input bit with_end);
        for (int k = 0; k < 64; k++)
            rom[base+k] = mkw(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 2'($urandom_range(0, 1)));
        if (with_end)
            rom[base+npts] = mkw(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 2'($urandom_range(2, 3)));
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_go"},        64'(go_a),        64'(0));
        check({p, "_ram_we"},    64'(ram_we_a),    64'(0));
        check({p, "_rom_adr"},   64'(rom_adr_a),   64'(0));
        check({p, "_ram_wadr"},  64'(ram_wadr_a),  64'(0));
        check({p, "_ram_wdata"}, 64'(ram_wdata_a), 64'(0));
        check({p, "_frame_len"}, 64'(frame_len_a), 64'(0));
        check({p, "_overflow"},  64'(overflow_a),  64'(0));
        check({p, "_go_b"},      64'(go_b),        64'(0));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int ca, cb, base, lows, wbase, cyc;

        for (int i = 0; i < 65536; i++) rom[i] = mkw(0, 0, 2'b11);
        rom[16'h0100] = mkw(1, 2, CMD_DRAW);
        rom[16'h0101] = mkw(-3, 4, CMD_DRAW);
        rom[16'h0102] = mkw(5, -6, CMD_DRAW);
        rom[16'h0103] = mkw(0, 0, CMD_END);
        rom[16'h0200] = mkw(10, -5, CMD_DRAW);
        rom[16'h0201] = mkw(0, 0, 2'b10);
        rom[16'h0210] = mkw(-5, 10, CMD_MOVE);
        rom[16'h0211] = mkw(0, 0, CMD_END);
        fill_region(16'h0300, 20, 1);
        fill_region(16'h0400, 0, 0);
        fill_region(16'h0500, 2, 1);

        halt_a = 0; halt_b = 0;
        v_a = 4'b0001; v_b = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            x_a[i] = 8'($urandom_range(0, 255)); y_a[i] = 8'($urandom_range(0, 255));
            x_b[i] = 8'($urandom_range(0, 255)); y_b[i] = 8'($urandom_range(0, 255));
            adr_a[i] = 16'h0100; adr_b[i] = 16'h0300;
        end
        x_a[0] = 8'd40; y_a[0] = 8'd50;

        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst0");

        // Reset release: first frame built straight away.
        model(0);
        model(1);
        rst = 1'b1;
        wait_both(0, ca, cb);
        check_frame(0, 0, ca);
        check_frame(1, 0, cb);
        check("a_go_after_snapshot", 64'(ca), 64'(11));
        check("a_end_marker", 64'(wdat_a_log.size() > 3 ? wdat_a_log[3] : 18'h3ffff), 64'(18'h00003));
        check("b_ovf_frame_len", 64'(frame_len_b), 64'(8));
        check("b_ovf_flag", 64'(overflow_b), 64'(1));

        // Hold halt low: go stays high, no writes; positions move meanwhile.
        lows = 0;
        wbase = wdat_a_log.size();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (go_a !== 1'b1) lows++;
            if (c == 50) begin x_a[0] = 8'($urandom_range(0, 255)); y_a[0] = 8'($urandom_range(0, 255)); end
        end
        check("a_go_held", 64'(lows), 64'(0));
        check("a_no_writes_ready", 64'(wdat_a_log.size() - wbase), 64'(0));
        run_frame(0, base);

        // Saturate vs wrap.
        v_a = 4'b0011; v_b = 4'b0011;
        x_a[0] = 8'd250; x_a[1] = 8'd3; y_a[0] = 8'd100; y_a[1] = 8'd100;
        adr_a[0] = 16'h0200; adr_a[1] = 16'h0210;
        x_b[0] = 8'd250; x_b[1] = 8'd3; y_b[0] = 8'd100; y_b[1] = 8'd100;
        adr_b[0] = 16'h0200; adr_b[1] = 16'h0210;
        run_frame(0, base);
        check("a_sat_hi", 64'(wdat_a_log[base][17:10]), 64'(255));
        check("a_sat_lo", 64'(wdat_a_log[base+1][17:10]), 64'(0));
        run_frame(1, base);
        check("b_wrap_hi", 64'(wdat_b_log[base][17:10]), 64'(4));
        check("b_wrap_lo", 64'(wdat_b_log[base+1][17:10]), 64'(254));
        check("b_ovf_cleared", 64'(overflow_b), 64'(0));

        // Sprite without END: cut at 16 words, then the next channel.
        v_a = 4'b0101;
        adr_a[0] = 16'h0400; adr_a[2] = 16'h0200;
        run_frame(0, base);
        check("a_maxlen_frame_len", 64'(frame_len_a), 64'(18));

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            v_a = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                x_a[i] = 8'($urandom_range(0, 255));
                y_a[i] = 8'($urandom_range(0, 255));
                adr_a[i] = 16'(16'h1000 + i * 64);
                fill_region(16'h1000 + i * 64, int'($urandom_range(0, 20)), 1'($urandom_range(0, 3) != 0));
            end
            run_frame(0, base);
        end

        // Reset mid-COPY, then inputs change right after the new snapshot.
        v_a = 4'b0001;
        adr_a[0] = 16'h0400;
        halt_a = 1'b1;
        @(negedge clk);
        halt_a = 1'b0;
        repeat (3) @(negedge clk);
        check("a_in_copy_we", 64'(ram_we_a), 64'(1));
        rst = 1'b0;
        #1;
        check_reset_outputs("rst1");
        v_a = 4'b0010;
        x_a[1] = 8'($urandom_range(0, 255));
        y_a[1] = 8'($urandom_range(0, 255));
        adr_a[1] = 16'h0210;
        model(0);
        model(1);
        ca = wdat_a_log.size();
        cb = wdat_b_log.size();
        @(negedge clk);
        rst = 1'b1;
        base = ca;
        wbase = cb;
        wait_both(1, ca, cb);
        check_frame(0, base, ca);
        check_frame(1, wbase, cb);

        // Frame after the mutated inputs now reflects them.
        run_frame(0, base);
        cyc = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + cyc);
        $finish;
    end

endmodule
